// File: rtl/slength_decoder_if.sv
// Bit-stream and match-length handshake bundle between the literal/length dispatcher,
// the fixed-Huffman length decoder and the LZ77 copy engine.
interface slength_decoder_if #(
    parameter int LEN_W = 9
) ();
    logic             flush_in;
    logic             bit_in;
    logic             bit_valid_in;
    logic             bit_ready_out;
    logic [LEN_W-1:0] match_length_out;
    logic             eob_out;
    logic             match_length_valid_out;
    logic             match_length_ready_in;
    logic             error_out;

    modport master (
        output flush_in, bit_in, bit_valid_in, match_length_ready_in,
        input  bit_ready_out, match_length_out, eob_out, match_length_valid_out, error_out
    );

    modport slave (
        input  flush_in, bit_in, bit_valid_in, match_length_ready_in,
        output bit_ready_out, match_length_out, eob_out, match_length_valid_out, error_out
    );
endinterface

// File: rtl/slength_decoder.sv
// Bit-serial DEFLATE fixed-Huffman length-symbol decoder (256..285): MSB-first 7/8-bit code
// followed by LSB-first extra bits, producing match_length 3..258 or an end-of-block flag.
module slength_decoder #(
    parameter int LEN_W      = 9,
    parameter bit ALLOW_258X = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    slength_decoder_if.slave sif
);

    typedef enum logic [2:0] {
        S_CODE,
        S_CODE8,
        S_EXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_d;
    logic [6:0]       code, code_d;
    logic [2:0]       cnt, cnt_d;
    logic [8:0]       base, base_d;
    logic [2:0]       nx, nx_d;
    logic [4:0]       extra, extra_d;
    logic [LEN_W-1:0] len, len_d;
    logic             eob, eob_d;

    logic             take;
    logic [6:0]       c7;
    logic [7:0]       c8;
    logic [4:0]       idx;
    logic [4:0]       extra_in;
    logic [8:0]       sum;

    // Symbols 265..284 as idx 0..19: four symbols per extra-bit group g,
    // base = ((4 + j) << (g + 1)) + 3 with j the position inside the group.
    function automatic logic [8:0] base_of(input logic [4:0] i);
        logic [8:0] m;
        m = {6'd0, 1'b1, i[1:0]};
        return (m << ({1'b0, i[4:2]} + 4'd1)) + 9'd3;
    endfunction

    function automatic logic [2:0] nx_of(input logic [4:0] i);
        return i[4:2] + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CODE;
            code  <= '0;
            cnt   <= '0;
            base  <= '0;
            nx    <= '0;
            extra <= '0;
            len   <= '0;
            eob   <= 1'b0;
        end else begin
            state <= state_d;
            code  <= code_d;
            cnt   <= cnt_d;
            base  <= base_d;
            nx    <= nx_d;
            extra <= extra_d;
            len   <= len_d;
            eob   <= eob_d;
        end
    end

    always_comb begin
        state_d  = state;
        code_d   = code;
        cnt_d    = cnt;
        base_d   = base;
        nx_d     = nx;
        extra_d  = extra;
        len_d    = len;
        eob_d    = eob;
        idx      = '0;
        take     = sif.bit_valid_in &&
                   (state == S_CODE || state == S_CODE8 || state == S_EXT);
        c7       = {code[5:0], sif.bit_in};
        c8       = {code, sif.bit_in};
        extra_in = extra | (5'(sif.bit_in) << cnt);
        sum      = base + {4'd0, extra_in};

        if (sif.flush_in) begin
            state_d = S_CODE;
            code_d  = '0;
            cnt_d   = '0;
            extra_d = '0;
            eob_d   = 1'b0;
        end else begin
            case (state)
                S_CODE: begin
                    if (take) begin
                        code_d = c7;
                        if (cnt == 3'd6) begin
                            cnt_d = '0;
                            if (c7 == 7'd0) begin
                                len_d   = '0;
                                eob_d   = 1'b1;
                                state_d = S_DONE;
                            end else if (c7 <= 7'd8) begin
                                len_d   = LEN_W'(c7 + 7'd2);
                                eob_d   = 1'b0;
                                state_d = S_DONE;
                            end else if (c7 <= 7'd23) begin
                                idx     = 5'(c7 - 7'd9);
                                base_d  = base_of(idx);
                                nx_d    = nx_of(idx);
                                extra_d = '0;
                                state_d = S_EXT;
                            end else if (c7 >= 7'h60 && c7 <= 7'h63) begin
                                state_d = S_CODE8;
                            end else begin
                                state_d = S_ERR;
                            end
                        end else begin
                            cnt_d = cnt + 3'd1;
                        end
                    end
                end
                S_CODE8: begin
                    if (take) begin
                        if (c8 <= 8'd196) begin
                            idx     = 5'(c8 - 8'd177);
                            base_d  = base_of(idx);
                            nx_d    = nx_of(idx);
                            extra_d = '0;
                            state_d = S_EXT;
                        end else if (c8 == 8'd197) begin
                            len_d   = LEN_W'(9'd258);
                            eob_d   = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_EXT: begin
                    if (take) begin
                        extra_d = extra_in;
                        if (cnt == nx - 3'd1) begin
                            cnt_d = '0;
                            if (base == 9'd227 && extra_in == 5'd31 && !ALLOW_258X) begin
                                state_d = S_ERR;
                            end else begin
                                len_d   = LEN_W'(sum);
                                eob_d   = 1'b0;
                                state_d = S_DONE;
                            end
                        end else begin
                            cnt_d = cnt + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (sif.match_length_ready_in) begin
                        code_d  = '0;
                        cnt_d   = '0;
                        state_d = S_CODE;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    assign sif.bit_ready_out          = (state == S_CODE) || (state == S_CODE8) || (state == S_EXT);
    assign sif.match_length_valid_out = (state == S_DONE);
    assign sif.error_out              = (state == S_ERR);
    assign sif.match_length_out       = len;
    assign sif.eob_out                = eob;

endmodule

// File: tb/tb_slength_decoder.sv
// Directed-vector bench for slength_decoder: hand-computed lengths, EOB, error codes,
// flush and reset behaviour, output hold under back-pressure.
module tb_slength_decoder;

    localparam int LEN_W = 9;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    slength_decoder_if #(.LEN_W(LEN_W)) bus ();

    slength_decoder #(.LEN_W(LEN_W), .ALLOW_258X(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        bus.bit_in       = b;
        bus.bit_valid_in = 1'b1;
        tick();
        bus.bit_valid_in = 1'b0;
    endtask

    task automatic send_code(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) put_bit(v[i]);
    endtask

    task automatic send_ext(input logic [4:0] v, input int n);
        for (int i = 0; i < n; i++) put_bit(v[i]);
    endtask

    task automatic flush();
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int len, input logic eob);
        check({tag, "_valid"}, bus.match_length_valid_out, 1);
        check({tag, "_len"}, bus.match_length_out, len);
        check({tag, "_eob"}, bus.eob_out, eob);
        check({tag, "_rdy_lo"}, bus.bit_ready_out, 0);
        bus.match_length_ready_in = 1'b1;
        tick();
        bus.match_length_ready_in = 1'b0;
        check({tag, "_rdy_hi"}, bus.bit_ready_out, 1);
        check({tag, "_valid_lo"}, bus.match_length_valid_out, 0);
    endtask

    task automatic expect_error(input string tag);
        check({tag, "_err"}, bus.error_out, 1);
        check({tag, "_rdy"}, bus.bit_ready_out, 0);
        check({tag, "_valid"}, bus.match_length_valid_out, 0);
        flush();
        check({tag, "_err_clr"}, bus.error_out, 0);
        check({tag, "_rdy_clr"}, bus.bit_ready_out, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"}, bus.bit_ready_out, 1);
        check({tag, "_valid"}, bus.match_length_valid_out, 0);
        check({tag, "_len"}, bus.match_length_out, 0);
        check({tag, "_eob"}, bus.eob_out, 0);
        check({tag, "_err"}, bus.error_out, 0);
    endtask

    initial begin
        checks                    = 0;
        failures                  = 0;
        rst_n                     = 1'b0;
        bus.flush_in              = 1'b0;
        bus.bit_in                = 1'b0;
        bus.bit_valid_in          = 1'b0;
        bus.match_length_ready_in = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Short codes with no extra bits
        send_code(8'b0000001, 7);  expect_result("sym257", 3, 0);
        send_code(8'b0001000, 7);  expect_result("sym264", 10, 0);

        // 7-bit codes with extra bits (LSB-first)
        send_code(8'b0001001, 7);  send_ext(5'b1, 1);     expect_result("sym265", 12, 0);
        send_code(8'b0010111, 7);  send_ext(5'b1111, 4);  expect_result("sym279", 114, 0);
        send_code(8'b0001101, 7);  send_ext(5'b10, 2);    expect_result("sym269", 21, 0);

        // 8-bit codes
        send_code(8'b11000001, 8); send_ext(5'd20, 5);    expect_result("sym281", 151, 0);
        send_code(8'b11000100, 8); send_ext(5'd30, 5);    expect_result("sym284", 257, 0);
        send_code(8'b11000101, 8);                        expect_result("sym285", 258, 0);
        send_code(8'b0000000, 7);                         expect_result("eob", 0, 1);

        // Invalid codes, each cleared by a one-cycle flush
        send_code(8'b11000110, 8);
        bus.bit_in = 1'b1; bus.bit_valid_in = 1'b1;
        repeat (2) tick();
        bus.bit_valid_in = 1'b0;
        expect_error("sym286");
        send_code(8'b0000010, 7);  expect_result("post_flush", 4, 0);
        send_code(8'b0110000, 7);  expect_error("literal");
        send_code(8'b11000100, 8); send_ext(5'd31, 5);    expect_error("sym284x31");

        // Back-pressure: result held, no bit consumed while waiting
        send_code(8'b0000011, 7);
        bus.bit_in = 1'b1; bus.bit_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", bus.match_length_valid_out, 1);
            check("hold_len", bus.match_length_out, 5);
            check("hold_rdy", bus.bit_ready_out, 0);
            tick();
        end
        bus.bit_valid_in = 1'b0;
        expect_result("hold_end", 5, 0);
        send_code(8'b0000001, 7);  expect_result("after_hold", 3, 0);

        // Flush in the middle of the extra bits
        send_code(8'b11000001, 8); send_ext(5'b01, 2);
        check("midext_rdy", bus.bit_ready_out, 1);
        flush();
        send_code(8'b0000011, 7);  expect_result("after_midflush", 5, 0);

        // Asynchronous reset mid-code
        send_code(8'b101, 3);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        #2 rst_n = 1'b1;
        tick();
        send_code(8'b0000001, 7);  expect_result("after_reset", 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
